// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// controller state encoding and a packed-vector lane slicing macro.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// Select lane idx of width w from a packed multi-port vector.
`ifndef RF_SLICE
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear engine: walks every entry once, writing zero, and
// holds busy high until the last entry has been cleared.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  // Advance the clear pointer; leave CLEAR on the edge that clears the last
  // entry and hold the pointer there so it never starts a second pass.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      if (clr_ptr_q == LAST_ADDR) begin
        state_d = ST_READY;
      end else begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      end
    end
  end

  // State register; reset (even mid-clear) restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with optional zero register,
// same-cycle write-to-read bypass and a sequential post-reset clear.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Next storage contents: the clear write takes the array exclusively;
  // otherwise user ports apply in index order so the highest port wins.
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && !((ZERO_REG != 0) && (`RF_SLICE(wr_addr, k, ADDR_W) == '0))) begin
          mem_d[`RF_SLICE(wr_addr, k, ADDR_W)] = `RF_SLICE(wr_data, k, DATA_W);
        end
      end
    end
  end

  // Storage array; contents are defined only after the clear sweep.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read lanes: stored value, then bypass from the highest matching write
  // port, then the zero register override, and all zeros while clearing.
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      `RF_SLICE(rd_data, j, DATA_W) = mem_q[`RF_SLICE(rd_addr, j, ADDR_W)];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (`RF_SLICE(wr_addr, k, ADDR_W) == `RF_SLICE(rd_addr, j, ADDR_W))) begin
            `RF_SLICE(rd_data, j, DATA_W) = `RF_SLICE(wr_data, k, DATA_W);
          end
        end
      end
      if ((ZERO_REG != 0) && (`RF_SLICE(rd_addr, j, ADDR_W) == '0)) begin
        `RF_SLICE(rd_data, j, DATA_W) = '0;
      end
      if (busy) begin
        `RF_SLICE(rd_data, j, DATA_W) = '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (zero-reg + bypass, and plain)
// share stimulus and are compared against an array-based reference model.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data_a;
  logic [2*DW-1:0] rd_data_b;
  logic          busy_a;
  logic          busy_b;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  int            remaining = DEPTH;

  reg_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .busy(busy_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a)
  );

  reg_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .busy(busy_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  // Model effect of one clock edge with the current inputs.
  task automatic model_commit();
    logic [AW-1:0] a;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] = '0;
        mem_b[i] = '0;
      end
      remaining = DEPTH;
    end else if (remaining > 0) begin
      remaining--;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) begin
          a = wr_addr[k*AW +: AW];
          if (a != 0) mem_a[a] = wr_data[k*DW +: DW];
          mem_b[a] = wr_data[k*DW +: DW];
        end
      end
    end
  endtask

  // Expected lane value: which=0 is the zero-reg/bypass instance, 1 the plain one.
  function automatic logic [DW-1:0] exp_rd(input int which, input logic [AW-1:0] ra);
    if (remaining > 0) return '0;
    if (which == 0) begin
      if (ra == 0) return '0;
      for (int k = 1; k >= 0; k--) begin
        if (wr_en[k] && wr_addr[k*AW +: AW] == ra) return wr_data[k*DW +: DW];
      end
      return mem_a[ra];
    end
    return mem_b[ra];
  endfunction

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_busy got=%b%b want=11", busy_a, busy_b);
    end
    wr_en = 2'b01;
    wr_addr[AW-1:0] = 5'd3;
    wr_data[DW-1:0] = 32'h0000DEAD;
    rd_addr = {5'd3, 5'd3};
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 100) begin
      #1;
      for (int j = 0; j < 2; j++) begin
        total++;
        if (rd_data_a[j*DW +: DW] !== 32'h0 || rd_data_b[j*DW +: DW] !== 32'h0) begin
          bad++;
          $display("[TB] FAIL clear_rd lane%0d got=%h/%h want=0", j,
                   rd_data_a[j*DW +: DW], rd_data_b[j*DW +: DW]);
        end
      end
      tick();
      cnt++;
      total++;
      if (busy_b !== (remaining > 0)) begin
        bad++;
        $display("[TB] FAIL clear_busy_b got=%b want=%b", busy_b, remaining > 0);
      end
    end
    total++;
    if (cnt !== DEPTH) begin
      bad++;
      $display("[TB] FAIL clear_len got=%0d want=%0d", cnt, DEPTH);
    end
    wr_en = '0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {a[AW-1:0], a[AW-1:0]};
      #1;
      for (int j = 0; j < 2; j++) begin
        total++;
        if (rd_data_a[j*DW +: DW] !== 32'h0 || rd_data_b[j*DW +: DW] !== 32'h0) begin
          bad++;
          $display("[TB] FAIL post_clear addr=%0d lane%0d got=%h/%h want=0", a, j,
                   rd_data_a[j*DW +: DW], rd_data_b[j*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_busy got=%b%b want=11", busy_a, busy_b);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    total++;
    if (cnt !== DEPTH) begin
      bad++;
      $display("[TB] FAIL mid_len got=%0d want=%0d", cnt, DEPTH);
    end
    total++;
    if (busy_b !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_busy_b got=%b want=0", busy_b);
    end
  endtask

  // Drive one write/read pattern, check the same cycle and the following one.
  task automatic write_and_check(input string name, input logic [1:0] en,
                                 input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
    rd_addr = {r1, r0};
    #1;
    for (int j = 0; j < 2; j++) begin
      total++;
      if (rd_data_a[j*DW +: DW] !== exp_rd(0, rd_addr[j*AW +: AW])) begin
        bad++;
        $display("[TB] FAIL %s_same_a lane%0d got=%h want=%h", name, j,
                 rd_data_a[j*DW +: DW], exp_rd(0, rd_addr[j*AW +: AW]));
      end
      total++;
      if (rd_data_b[j*DW +: DW] !== exp_rd(1, rd_addr[j*AW +: AW])) begin
        bad++;
        $display("[TB] FAIL %s_same_b lane%0d got=%h want=%h", name, j,
                 rd_data_b[j*DW +: DW], exp_rd(1, rd_addr[j*AW +: AW]));
      end
    end
    tick();
    wr_en = '0;
    #1;
    for (int j = 0; j < 2; j++) begin
      total++;
      if (rd_data_a[j*DW +: DW] !== exp_rd(0, rd_addr[j*AW +: AW])) begin
        bad++;
        $display("[TB] FAIL %s_next_a lane%0d got=%h want=%h", name, j,
                 rd_data_a[j*DW +: DW], exp_rd(0, rd_addr[j*AW +: AW]));
      end
      total++;
      if (rd_data_b[j*DW +: DW] !== exp_rd(1, rd_addr[j*AW +: AW])) begin
        bad++;
        $display("[TB] FAIL %s_next_b lane%0d got=%h want=%h", name, j,
                 rd_data_b[j*DW +: DW], exp_rd(1, rd_addr[j*AW +: AW]));
      end
    end
  endtask

  task automatic test_basic();
    write_and_check("basic", 2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0, 5'd7, 5'd7);
    total++;
    if (rd_data_b[DW-1:0] !== 32'h12345678 || rd_data_b[2*DW-1:DW] !== 32'h12345678) begin
      bad++;
      $display("[TB] FAIL basic_const got=%h want=12345678", rd_data_b);
    end
  endtask

  task automatic test_bypass();
    write_and_check("bypass", 2'b01, 5'd9, 32'hCAFEBABE, 5'd0, 32'h0, 5'd9, 5'd7);
  endtask

  task automatic test_priority();
    write_and_check("prio", 2'b11, 5'd4, 32'h00001111, 5'd4, 32'h00002222, 5'd4, 5'd4);
    total++;
    if (rd_data_a[DW-1:0] !== 32'h00002222 || rd_data_b[DW-1:0] !== 32'h00002222) begin
      bad++;
      $display("[TB] FAIL prio_const got=%h/%h want=00002222", rd_data_a[DW-1:0], rd_data_b[DW-1:0]);
    end
  endtask

  task automatic test_zero();
    write_and_check("zero", 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 5'd0);
    total++;
    if (rd_data_a[DW-1:0] !== 32'h0 || rd_data_b[DW-1:0] !== 32'hFFFFFFFF) begin
      bad++;
      $display("[TB] FAIL zero_const got=%h/%h want=00000000/ffffffff",
               rd_data_a[DW-1:0], rd_data_b[DW-1:0]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ra;
    for (int c = 0; c < 400; c++) begin
      wr_en = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        wr_addr[k*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        wr_data[k*DW +: DW] = $urandom;
      end
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 2))
          0: rd_addr[j*AW +: AW] = wr_addr[AW-1:0];
          1: rd_addr[j*AW +: AW] = wr_addr[2*AW-1:AW];
          default: rd_addr[j*AW +: AW] = AW'($urandom);
        endcase
      end
      #1;
      total++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rand_busy cyc=%0d got=%b%b want=00", c, busy_a, busy_b);
      end
      for (int j = 0; j < 2; j++) begin
        ra = rd_addr[j*AW +: AW];
        total++;
        if (rd_data_a[j*DW +: DW] !== exp_rd(0, ra)) begin
          bad++;
          $display("[TB] FAIL rand_a cyc=%0d lane%0d addr=%0d got=%h want=%h", c, j, ra,
                   rd_data_a[j*DW +: DW], exp_rd(0, ra));
        end
        total++;
        if (rd_data_b[j*DW +: DW] !== exp_rd(1, ra)) begin
          bad++;
          $display("[TB] FAIL rand_b cyc=%0d lane%0d addr=%0d got=%h want=%h", c, j, ra,
                   rd_data_b[j*DW +: DW], exp_rd(1, ra));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_basic();
    test_bypass();
    test_priority();
    test_zero();
    test_random();
    test_reset_mid();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port successor to the single-write, dual-read register file used by the core datapath. It adds:
- configurable width, depth and port counts
- an optional hardwired zero register
- optional same-cycle write-to-read bypass
- deterministic write-port priority
- a sequential post-reset clear engine with a busy flag

It sits between decode (read addresses) and writeback (write ports) in single- and dual-issue pipelines.

Parameters:
- DATA_W, 32, bits per register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, read ports (1..4).
- NUM_WR, 1, write ports (1..2).
- ZERO_REG, 1, if 1, entry 0 reads as 0 and ignores writes.
- BYPASS, 1, if 1, a read of an address written in the same cycle returns the new data.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset; starts the clear sequence.
- busy  out  1  high while the clear sequence runs.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  packed; port k at bits [k*ADDR_W +: ADDR_W].
- wr_data  in  NUM_WR*DATA_W  packed; port k at bits [k*DATA_W +: DATA_W].
- rd_addr  in  NUM_RD*ADDR_W  packed, same slicing as wr_addr.
- rd_data  out  NUM_RD*DATA_W  packed, combinational read result.

Behaviour:
- State machine: two states, CLEAR and READY.
  - rst=1 at a clk edge: next state CLEAR, clr_ptr <= 0. Applies in any state, including mid-clear, which restarts the sequence from 0.
  - CLEAR with rst=0: each edge writes 0 to entry clr_ptr, then clr_ptr increments.
  - On the edge that clears entry DEPTH-1, state goes to READY.
- Clear latency: busy is high from the edge where rst is sampled through exactly DEPTH edges after rst is sampled low. With ADDR_W=5, busy falls on the 32nd edge after rst deasserts.
- busy is combinational from the state: busy = (state==CLEAR).
- Power-up state is don't-care. rst is required before first use.
- In CLEAR:
  - all wr_en are ignored;
  - every rd_data lane reads 0;
  - the bypass path is disabled.
- Writes in READY: on a clk edge, for each k with wr_en[k]=1, entry wr_addr[k] <= wr_data[k].
  - If two ports target the same address in one cycle, the higher port index wins.
  - If ZERO_REG=1, writes to address 0 are dropped silently.
- Reads in READY: rd_data[j] = mem[rd_addr[j]], combinational with zero-cycle latency.
  - If ZERO_REG=1 and rd_addr[j]==0, the result is 0. This overrides the bypass.
  - If BYPASS=1 and some port k has wr_en[k]=1 with wr_addr[k]==rd_addr[j], the result is wr_data of the highest such k.
  - If BYPASS=0, the read returns the pre-edge stored value. The new value is visible from the next cycle.
- Read ports are fully independent. Identical addresses on multiple ports return identical data.
- No X propagation into rd_data after clear completes. Every entry is defined.
- Width rules: no arithmetic on data. clr_ptr is ADDR_W bits and must not wrap into a second pass; the state change occurs on the edge where clr_ptr==DEPTH-1.

Decomposition:
- Shared package/include (regfile_pkg):
  - localparams for default DATA_W/ADDR_W;
  - state encodings ST_CLEAR=1'b0, ST_READY=1'b1;
  - a packed-slice helper macro for the port arrays.
- One natural sub-module, regfile_clear_fsm: owns state, clr_ptr and busy; outputs clr_we and clr_addr.
- The top muxes the clear write ahead of the user write ports. Storage, the priority write loop and the bypass/zero read muxes stay in reg_file_mp.

Test Plan:
- Reset/clear: pulse rst 1 cycle with ADDR_W=5. Required: busy=1 for 32 edges after rst low, then 0. Every address then reads 0x00000000. During busy, wr_en=1 to addr 3 with 0xDEAD has no effect.
- Reset mid-clear: reassert rst at clr_ptr=10. Required: busy stays high and falls 32 edges after the second rst deasserts.
- Basic write/read (BYPASS=0): write 0x12345678 to r7. Required: same-cycle read of r7 returns the old value 0. The next cycle returns 0x12345678 on both read ports.
- Bypass (BYPASS=1): write 0xCAFEBABE to r9 while rd_addr0=9. Required: rd_data0=0xCAFEBABE in the same cycle.
- Priority (NUM_WR=2): port0 writes 0x1111 and port1 writes 0x2222, both to r4. Required: r4 reads 0x2222 next cycle, and the bypass shows 0x2222 in the same cycle.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0. Required: rd_data=0 both in the same cycle (bypass suppressed) and the next cycle. With ZERO_REG=0, r0 reads 0xFFFFFFFF next cycle.
